// File: rtl/prng_serial_gen.sv
// Byte-serial Galois LFSR PRNG: seeded MSB-first, read out LSB-first, valid/ready on both sides.
// Define PRNG_ZERO_SEED_GUARD_EN to replace an all-zero assembled seed with RESET_SEED.
module prng_serial_gen #(
  parameter int                LFSR_W     = 32,
  parameter logic [LFSR_W-1:0] TAPS       = LFSR_W'(32'h8020_0003),
  parameter int                SHIFTS     = 8,
  parameter logic [LFSR_W-1:0] RESET_SEED = LFSR_W'(1)
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       load_seed,
  input  logic       din_valid,
  input  logic [7:0] data_in,
  output logic       din_ready,
  input  logic       get_random,
  output logic [7:0] data_out,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       busy
);
  localparam int NBYTES = LFSR_W / 8;
  localparam int CW     = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
  localparam logic [7:0]    LAST_STEP = 8'(SHIFTS - 1);

  typedef enum logic [1:0] {IDLE, SEEDLOAD, SHIFT, DATAOUT} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [7:0]        scnt;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] seed_next;
  logic [LFSR_W-1:0] step_next;

  // Seed bytes enter at the bottom, so the first byte ends up in the MSB.
  assign seed_next = {lfsr[LFSR_W-9:0], data_in};
  assign step_next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);

  assign din_ready  = (state == SEEDLOAD);
  assign dout_valid = (state == DATAOUT);
  assign busy       = (state != IDLE);
  assign data_out   = (state == DATAOUT) ? lfsr[{cnt, 3'b000} +: 8] : 8'h00;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      scnt  <= '0;
      lfsr  <= RESET_SEED;
    end else begin
      case (state)
        IDLE: begin
          if (load_seed) begin
            state <= SEEDLOAD;
            cnt   <= '0;
          end else if (get_random) begin
            state <= SHIFT;
            scnt  <= '0;
          end
        end
        SEEDLOAD: begin
          if (din_valid) begin
            if (cnt == LAST_BYTE) begin
              state <= IDLE;
              cnt   <= '0;
`ifdef PRNG_ZERO_SEED_GUARD_EN
              // An all-zero LFSR would lock up, so fall back to the reset seed.
              lfsr  <= (seed_next == '0) ? RESET_SEED : seed_next;
`else
              lfsr  <= seed_next;
`endif
            end else begin
              cnt  <= cnt + 1'b1;
              lfsr <= seed_next;
            end
          end
        end
        SHIFT: begin
          lfsr <= step_next;
          scnt <= scnt + 8'd1;
          if (scnt == LAST_STEP) begin
            state <= DATAOUT;
            cnt   <= '0;
          end
        end
        DATAOUT: begin
          if (dout_ready) begin
            if (cnt == LAST_BYTE) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prng_serial_gen.sv
// Bench for prng_serial_gen: two instances (SHIFTS=1 and SHIFTS=2), table vectors, corner sequences, random traffic.
module tb_prng_serial_gen;
  localparam int SH0 = 1;
  localparam int SH1 = 2;
  localparam logic [31:0] TAPS_TB = 32'h8020_0003;
`ifdef PRNG_ZERO_SEED_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    int          sel;
    bit          use_seed;
    logic [31:0] seed;
    int          mode;
    logic [31:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       load_seed [2];
  logic       din_valid [2];
  logic [7:0] data_in   [2];
  logic       din_ready [2];
  logic       get_random[2];
  logic [7:0] data_out  [2];
  logic       dout_valid[2];
  logic       dout_ready[2];
  logic       busy      [2];

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] model [2];

  always #5 clk = ~clk;

  prng_serial_gen #(.LFSR_W(32), .TAPS(TAPS_TB), .SHIFTS(SH0), .RESET_SEED(32'd1)) u0 (
    .clk(clk), .rstn(rstn), .load_seed(load_seed[0]), .din_valid(din_valid[0]),
    .data_in(data_in[0]), .din_ready(din_ready[0]), .get_random(get_random[0]),
    .data_out(data_out[0]), .dout_valid(dout_valid[0]), .dout_ready(dout_ready[0]),
    .busy(busy[0]));

  prng_serial_gen #(.LFSR_W(32), .TAPS(TAPS_TB), .SHIFTS(SH1), .RESET_SEED(32'd1)) u1 (
    .clk(clk), .rstn(rstn), .load_seed(load_seed[1]), .din_valid(din_valid[1]),
    .data_in(data_in[1]), .din_ready(din_ready[1]), .get_random(get_random[1]),
    .data_out(data_out[1]), .dout_valid(dout_valid[1]), .dout_ready(dout_ready[1]),
    .busy(busy[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] get_lfsr(input int s);
    return (s != 0) ? u1.lfsr : u0.lfsr;
  endfunction

  // Reference: n Galois steps applied as plain arithmetic on the word.
  function automatic logic [31:0] adv(input logic [31:0] v, input int n);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = r[0] ? ((r >> 1) ^ TAPS_TB) : (r >> 1);
    return r;
  endfunction

  task automatic check_idle_outputs(input string tag);
    for (int s = 0; s < 2; s++) begin
      chk({tag, "_busy"}, busy[s], 0);
      chk({tag, "_din_ready"}, din_ready[s], 0);
      chk({tag, "_dout_valid"}, dout_valid[s], 0);
      chk({tag, "_data_out"}, data_out[s], 0);
      chk({tag, "_lfsr"}, get_lfsr(s), 32'd1);
    end
  endtask

  task automatic do_seed(input int s, input logic [31:0] w, input bit gaps, input bit poke);
    int g;
    logic [7:0] b;
    load_seed[s] = 1'b1;
    @(negedge clk);
    load_seed[s] = 1'b0;
    chk("seed_busy", busy[s], 1);
    for (int i = 0; i < 4; i++) begin
      g = gaps ? int'($urandom % 3) : 0;
      if (poke && g == 0) g = 1;
      for (int k = 0; k < g; k++) begin
        din_valid[s]  = 1'b0;
        get_random[s] = poke;
        @(negedge clk);
      end
      get_random[s] = 1'b0;
      chk("seed_din_ready", din_ready[s], 1);
      b = w[31-8*i -: 8];
      data_in[s]   = b;
      din_valid[s] = 1'b1;
      @(negedge clk);
    end
    din_valid[s] = 1'b0;
    chk("seed_done_idle", busy[s], 0);
    chk("seed_done_ready", din_ready[s], 0);
    model[s] = (w == 32'd0 && GUARD) ? 32'd1 : w;
    chk("seed_lfsr", get_lfsr(s), model[s]);
  endtask

  // mode 0: ready held high; 1: random ready; 2: ready low 3 cycles on byte 1
  task automatic do_read(input int s, input int mode, input logic [31:0] exp);
    int waited, cnt, cyc, stall;
    bit rdy;
    waited = 0; cnt = 0; cyc = 0; stall = 0;
    get_random[s] = 1'b1;
    @(negedge clk);
    get_random[s] = 1'b0;
    chk("req_busy", busy[s], 1);
    while (!dout_valid[s] && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    chk("first_valid_latency", waited, (s != 0) ? SH1 : SH0);
    while (cnt < 4 && cyc < 300) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (($urandom & 32'd1) != 0);
        default: begin
          rdy = !(cnt == 1 && stall < 3);
          if (!rdy) stall++;
        end
      endcase
      dout_ready[s] = rdy;
      chk("out_valid", dout_valid[s], 1);
      chk("out_byte", data_out[s], exp[8*cnt +: 8]);
      @(negedge clk);
      cyc++;
      if (rdy) cnt++;
    end
    dout_ready[s] = 1'b0;
    chk("readout_handshakes", cnt, 4);
    if (mode == 0) chk("readout_cycles", cyc, 4);
    if (mode == 2) chk("readout_cycles_stall", cyc, 7);
    chk("read_end_idle", busy[s], 0);
    chk("read_end_valid", dout_valid[s], 0);
    chk("read_end_data", data_out[s], 0);
    model[s] = exp;
  endtask

  initial begin
    vec_t        vecs[5];
    int          s;
    logic [31:0] w;

    vecs[0] = '{sel: 0, use_seed: 0, seed: 32'h0,        mode: 0, exp: 32'h8020_0003};
    vecs[1] = '{sel: 0, use_seed: 1, seed: 32'h1234_5678, mode: 0, exp: 32'h091A_2B3C};
    vecs[2] = '{sel: 1, use_seed: 1, seed: 32'h0,        mode: 0,
                exp: GUARD ? 32'hC030_0002 : 32'h0};
    vecs[3] = '{sel: 0, use_seed: 1, seed: 32'hFFFF_FFFF, mode: 2, exp: 32'hFFDF_FFFC};
    vecs[4] = '{sel: 1, use_seed: 1, seed: 32'h1234_5678, mode: 0, exp: 32'h048D_159E};

    for (int i = 0; i < 2; i++) begin
      load_seed[i] = 0; din_valid[i] = 0; data_in[i] = 0;
      get_random[i] = 0; dout_ready[i] = 0;
      model[i] = 32'd1;
    end
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rstn = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].use_seed) do_seed(vecs[v].sel, vecs[v].seed, 1'b0, 1'b0);
      do_read(vecs[v].sel, vecs[v].mode, vecs[v].exp);
    end

    // Seed with gaps while get_random is poked: same word, no readout afterwards.
    do_seed(0, 32'h1234_5678, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("poke_no_valid", dout_valid[0], 0);
      chk("poke_idle", busy[0], 0);
    end
    do_read(0, 0, 32'h091A_2B3C);

    // load_seed and get_random together, then reset after two seed bytes.
    load_seed[0] = 1'b1; get_random[0] = 1'b1;
    @(negedge clk);
    load_seed[0] = 1'b0; get_random[0] = 1'b0;
    chk("both_req_din_ready", din_ready[0], 1);
    chk("both_req_no_valid", dout_valid[0], 0);
    din_valid[0] = 1'b1; data_in[0] = 8'hAA;
    @(negedge clk);
    data_in[0] = 8'hBB;
    @(negedge clk);
    din_valid[0] = 1'b0;
    chk("partial_still_loading", din_ready[0], 1);
    rstn = 1'b0;
    #1;
    check_idle_outputs("midreset");
    @(negedge clk);
    rstn = 1'b1;
    model[0] = 32'd1; model[1] = 32'd1;
    @(negedge clk);
    do_read(0, 0, 32'h8020_0003);

    for (int it = 0; it < 30; it++) begin
      s = int'($urandom % 2);
      if (($urandom % 3) == 0) begin
        w = (($urandom % 5) == 0) ? 32'd0 : $urandom;
        do_seed(s, w, 1'b1, 1'b0);
      end else begin
        do_read(s, 1, adv(model[s], (s != 0) ? SH1 : SH0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/prng_serial_gen.md
# prng_serial_gen

Parametrised byte-serial pseudo-random generator: a W-bit Galois LFSR that is seeded one byte at a time and read out one byte at a time. It is the next generation of the 32-bit extend-top PRNG. Compared with that block it adds a configurable LFSR width and polynomial, a configurable number of LFSR steps per request, and valid/ready handshakes on both seed input and data output. It sits between a byte-wide host/bus adapter and any consumer of random bytes.

## Interface
Parameters:
- `LFSR_W`, 32: LFSR width in bits; multiple of 8, range 16..64.
- `TAPS`, 32'h8020_0003: Galois feedback mask, `LFSR_W` bits wide.
- `SHIFTS`, 8: LFSR steps per `get_random` request; range 1..255.
- `RESET_SEED`, 1: LFSR value after reset; must be non-zero.
- Derived: `NBYTES` = `LFSR_W`/8; byte counter `CW` = clog2(`NBYTES`) bits.

Ports:
- `clk`, input, 1: the single clock.
- `rstn`, input, 1: asynchronous, active-low reset.
- `load_seed`, input, 1: request a seed load; sampled in IDLE only.
- `din_valid`, input, 1: `data_in` carries a seed byte.
- `data_in`, input, 8: seed byte.
- `din_ready`, output, 1: block accepts a seed byte; equals (state==SEEDLOAD).
- `get_random`, input, 1: request a random word; sampled in IDLE only.
- `data_out`, output, 8: current output byte; 0 when `dout_valid`=0.
- `dout_valid`, output, 1: equals (state==DATAOUT).
- `dout_ready`, input, 1: consumer accepts `data_out`.
- `busy`, output, 1: state != IDLE.

## Operation
FSM states: IDLE, SEEDLOAD, SHIFT, DATAOUT. Registered state, byte counter `cnt`, step counter `scnt` (8 bits) and `lfsr`.

- **IDLE**
  - `load_seed`=1: go to SEEDLOAD, clear `cnt`.
  - Else `get_random`=1: go to SHIFT, clear `scnt`.
  - Both high in the same cycle: `load_seed` wins and `get_random` is dropped.
- **SEEDLOAD**
  - Each cycle with `din_valid`=1: `lfsr` <= {`lfsr`[W-9:0], `data_in`} and `cnt`++.
  - The first byte ends up in the MSB position.
  - On the `NBYTES`th accepted byte: go to IDLE and clear `cnt`.
  - Cycles with `din_valid`=0 stall the load and change nothing.
- **SHIFT**
  - Every cycle: `lfsr` <= (`lfsr`>>1) ^ (`lfsr`[0] ? `TAPS` : 0) and `scnt`++.
  - After exactly `SHIFTS` steps: go to DATAOUT and clear `cnt`.
- **DATAOUT**
  - `data_out` = `lfsr`[8·cnt+7 : 8·cnt], so bytes are emitted LSB-first.
  - `cnt` advances only when `dout_valid` and `dout_ready` are both high.
  - When the last byte (cnt=`NBYTES`-1) is accepted: go to IDLE.
  - `lfsr` holds its value throughout DATAOUT.
- `load_seed` and `get_random` are ignored outside IDLE; they are not queued.
- `cnt` wraps only through the explicit clear, never modulo arithmetic.

## Timing
- Reset state: state=IDLE, `lfsr`=`RESET_SEED`, `cnt`=0, `scnt`=0.
- Outputs during reset: `data_out`=0, `dout_valid`=0, `din_ready`=0, `busy`=0.
- Reset asserted mid-operation aborts immediately and returns everything to the reset values. A partial seed is discarded.
- Request sampled at edge t: `busy`/`din_ready` rise at t+1.
- Seed load of `NBYTES` back-to-back bytes: IDLE again one cycle after the last accepted byte, with the new `lfsr` visible.
- `get_random` at edge t: first `dout_valid` at t+`SHIFTS`+1.
- Full readout with `dout_ready` held high: `NBYTES` cycles.
- When `dout_ready`=0, `data_out` and `dout_valid` hold stable.
- Minimum request-to-IDLE: `SHIFTS`+`NBYTES`+1 cycles.

## Configuration
- `PRNG_ZERO_SEED_GUARD_EN` defined:
  - If the fully assembled seed is all-zero, `lfsr` loads `RESET_SEED` instead.
  - The guard is checked on the final accepted seed byte.
- Not defined: zero is loaded as-is. The LFSR then stays at 0 and every output byte is 0x00.

## Test plan
- Reset, then `get_random` with `SHIFTS`=1, `LFSR_W`=32, `dout_ready`=1 -> `dout_valid` 2 cycles later; bytes 03, 00, 20, 80; then IDLE.
- Seed 12, 34, 56, 78 with `SHIFTS`=1, then `get_random` -> `lfsr`=0x12345678 after load; output 3C, 2B, 1A, 09.
- Seed load with `din_valid` gaps, and `get_random` pulsed during SEEDLOAD -> same `lfsr` as the gap-free load; `get_random` ignored, no readout.
- Readout with `dout_ready` low for 3 cycles on byte 1 -> byte 1 held stable, no skipped or duplicated bytes, 4 handshakes total.
- `load_seed`+`get_random` together in IDLE, then reset mid-SEEDLOAD after 2 bytes -> SEEDLOAD entered; after reset `lfsr`=1, outputs 0, state IDLE.
- Seed 00×4 -> with `PRNG_ZERO_SEED_GUARD_EN`: `lfsr`=1 and the next readout with `SHIFTS`=2 gives 02, 00, 30, C0. Without the macro: all bytes 00.
